sar_logic_tscs_10bit: RTL and testbench

SAR_LOGIC_TSCS_10BIT -- requirements
Module: sar_logic_tscs_10bit

---
 rtl/sar_logic_tscs_10bit.sv | 145 ++++++++++++++
 tb/tb_sar_logic_tscs_10bit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sar_logic_tscs_10bit.sv
// 10-bit two-step (coarse/fine split capacitor) SAR controller with differential switch arrays.
// Latency: eoc is high in the cycle after edge N+23 when cnvst is sampled at edge N. No backpressure: cnvst is sampled only in IDLE.
module sar_logic_tscs_10bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnvst,
  input  logic        cmp_out,
  output logic [9:0]  sar,
  output logic        eoc,
  output logic        cmp_clk,
  output logic        s_clk,
  output logic [12:0] fine_sca1_top,
  output logic [12:0] fine_sca1_btm,
  output logic [12:0] fine_sca2_top,
  output logic [12:0] fine_sca2_btm,
  output logic        fine_switch_S,
  output logic        fine_switch_drain,
  output logic        s_clk_not,
  output logic [12:0] fine_sca1_top_not,
  output logic [12:0] fine_sca1_btm_not,
  output logic [12:0] fine_sca2_top_not,
  output logic [12:0] fine_sca2_btm_not,
  output logic        fine_switch_S_not,
  output logic        fine_switch_drain_not
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_COARSE = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FINE   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]  state;
  logic [3:0]  bit_idx;
  logic        phase_b;
  logic        smp_cnt;
  logic [9:0]  sar_mask;
  logic [12:0] cap_mask;

  // Capacitor index k = bit + 3; indices 2..0 are dummies and never selected.
  assign sar_mask = 10'd1 << bit_idx;
  assign cap_mask = 13'd1 << (bit_idx + 4'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= ST_IDLE;
      bit_idx           <= 4'd0;
      phase_b           <= 1'b0;
      smp_cnt           <= 1'b0;
      sar               <= 10'd0;
      eoc               <= 1'b0;
      cmp_clk           <= 1'b0;
      s_clk             <= 1'b0;
      fine_sca1_top     <= 13'd0;
      fine_sca1_btm     <= 13'd0;
      fine_sca2_top     <= 13'd0;
      fine_sca2_btm     <= 13'd0;
      fine_switch_S     <= 1'b0;
      fine_switch_drain <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          eoc               <= 1'b0;
          cmp_clk           <= 1'b0;
          s_clk             <= 1'b0;
          fine_switch_S     <= 1'b0;
          fine_switch_drain <= 1'b0;
          if (cnvst) begin
            state         <= ST_SAMPLE;
            smp_cnt       <= 1'b0;
            s_clk         <= 1'b1;
            fine_switch_S <= 1'b1;
            sar           <= 10'd0;
            fine_sca1_top <= 13'd0;
            fine_sca1_btm <= 13'd0;
            fine_sca2_top <= 13'd0;
            fine_sca2_btm <= 13'd0;
          end
        end
        ST_SAMPLE: begin
          if (!smp_cnt) begin
            smp_cnt <= 1'b1;
          end else begin
            state   <= ST_COARSE;
            bit_idx <= 4'd9;
            phase_b <= 1'b0;
            cmp_clk <= 1'b1;
            s_clk   <= 1'b0;
          end
        end
        ST_COARSE, ST_FINE: begin
          if (!phase_b) begin
            phase_b <= 1'b1;
            cmp_clk <= 1'b0;
          end else begin
            // End of cycle B: commit the decision and switch the matching capacitor pair.
            if (cmp_out) begin
              sar           <= sar | sar_mask;
              fine_sca1_btm <= fine_sca1_btm | cap_mask;
              fine_sca2_top <= fine_sca2_top | cap_mask;
            end else begin
              sar           <= sar & ~sar_mask;
              fine_sca1_top <= fine_sca1_top | cap_mask;
              fine_sca2_btm <= fine_sca2_btm | cap_mask;
            end
            if (state == ST_COARSE && bit_idx == 4'd5) begin
              state             <= ST_DRAIN;
              fine_switch_drain <= 1'b1;
              fine_switch_S     <= 1'b0;
            end else if (state == ST_FINE && bit_idx == 4'd0) begin
              state <= ST_DONE;
              eoc   <= 1'b1;
            end else begin
              bit_idx <= bit_idx - 4'd1;
              phase_b <= 1'b0;
              cmp_clk <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state             <= ST_FINE;
          bit_idx           <= 4'd4;
          phase_b           <= 1'b0;
          fine_switch_drain <= 1'b0;
          cmp_clk           <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          eoc   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_clk_not             = ~s_clk;
  assign fine_sca1_top_not     = ~fine_sca1_top;
  assign fine_sca1_btm_not     = ~fine_sca1_btm;
  assign fine_sca2_top_not     = ~fine_sca2_top;
  assign fine_sca2_btm_not     = ~fine_sca2_btm;
  assign fine_switch_S_not     = ~fine_switch_S;
  assign fine_switch_drain_not = ~fine_switch_drain;

endmodule

// File: tb/tb_sar_logic_tscs_10bit.sv
// Randomized bench for sar_logic_tscs_10bit against a timeline reference model.
module tb_sar_logic_tscs_10bit;

  logic        clk = 1'b0;
  logic        rst, cnvst, cmp_out;
  logic [9:0]  sar;
  logic        eoc, cmp_clk, s_clk, fine_switch_S, fine_switch_drain;
  logic [12:0] fine_sca1_top, fine_sca1_btm, fine_sca2_top, fine_sca2_btm;
  logic        s_clk_not, fine_switch_S_not, fine_switch_drain_not;
  logic [12:0] fine_sca1_top_not, fine_sca1_btm_not, fine_sca2_top_not, fine_sca2_btm_not;

  always #5 clk = ~clk;

  sar_logic_tscs_10bit dut (
    .clk(clk), .rst(rst), .cnvst(cnvst), .cmp_out(cmp_out),
    .sar(sar), .eoc(eoc), .cmp_clk(cmp_clk), .s_clk(s_clk),
    .fine_sca1_top(fine_sca1_top), .fine_sca1_btm(fine_sca1_btm),
    .fine_sca2_top(fine_sca2_top), .fine_sca2_btm(fine_sca2_btm),
    .fine_switch_S(fine_switch_S), .fine_switch_drain(fine_switch_drain),
    .s_clk_not(s_clk_not),
    .fine_sca1_top_not(fine_sca1_top_not), .fine_sca1_btm_not(fine_sca1_btm_not),
    .fine_sca2_top_not(fine_sca2_top_not), .fine_sca2_btm_not(fine_sca2_btm_not),
    .fine_switch_S_not(fine_switch_S_not), .fine_switch_drain_not(fine_switch_drain_not)
  );

  int checks = 0;
  int failures = 0;

  // Model: t = cycles since the cnvst sampling edge, -1 when idle.
  int          t = -1;
  logic [9:0]  m_sar = '0;
  logic [12:0] m_top = '0;   // array 1 top; array 2 bottom mirrors it
  logic [12:0] m_btm = '0;   // array 1 bottom; array 2 top mirrors it
  int          cyc = 0;
  int          start_cyc = -1;
  int          last_eoc = -1;
  bit          b2b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit resolved at the edge that brings the model to offset tt, or -1.
  function automatic int res_bit(input int tt);
    if (tt >= 4 && tt <= 12 && tt % 2 == 0) return 9 - (tt - 4) / 2;
    if (tt >= 15 && tt <= 23 && tt % 2 == 1) return 4 - (tt - 15) / 2;
    return -1;
  endfunction

  task automatic check_outputs();
    logic [4:0] exp_ctl;
    bit a_on;
    a_on = (t >= 2 && t <= 11 && t % 2 == 0) || (t >= 13 && t <= 22 && t % 2 == 1);
    exp_ctl = {(t == 0 || t == 1), a_on, (t >= 0 && t <= 11), (t == 12), (t == 23)};
    chk("ctl{s_clk,cmp_clk,S,drain,eoc}", {27'd0, s_clk, cmp_clk, fine_switch_S, fine_switch_drain, eoc},
        {27'd0, exp_ctl});
    chk("sar", {22'd0, sar}, {22'd0, m_sar});
    chk("sca1_top", {19'd0, fine_sca1_top}, {19'd0, m_top});
    chk("sca1_btm", {19'd0, fine_sca1_btm}, {19'd0, m_btm});
    chk("sca2_top", {19'd0, fine_sca2_top}, {19'd0, m_btm});
    chk("sca2_btm", {19'd0, fine_sca2_btm}, {19'd0, m_top});
    chk("not_1bit", {29'd0, s_clk_not, fine_switch_S_not, fine_switch_drain_not},
        {29'd0, ~s_clk, ~fine_switch_S, ~fine_switch_drain});
    chk("not_sca1", {6'd0, fine_sca1_top_not, fine_sca1_btm_not}, {6'd0, ~fine_sca1_top, ~fine_sca1_btm});
    chk("not_sca2", {6'd0, fine_sca2_top_not, fine_sca2_btm_not}, {6'd0, ~fine_sca2_top, ~fine_sca2_btm});
    chk("top_btm_overlap", {19'd0, (fine_sca1_top & fine_sca1_btm) | (fine_sca2_top & fine_sca2_btm)}, 32'd0);
  endtask

  // One clock: drive inputs at negedge, update model at posedge, check #1 later.
  task automatic step(input logic rst_v, input logic cnvst_v, input bit noise, input logic [9:0] pat);
    int rb;
    @(negedge clk);
    rst   = rst_v;
    cnvst = cnvst_v;
    rb = (t >= 0) ? res_bit(t + 1) : -1;
    if (rb >= 0) cmp_out = pat[rb];
    else if (noise) cmp_out = 1'($urandom);
    else cmp_out = pat[0];
    @(posedge clk);
    cyc++;
    if (!rst_v) begin
      t = -1; m_sar = '0; m_top = '0; m_btm = '0;
    end else if (t < 0) begin
      if (cnvst_v) begin
        t = 0; m_sar = '0; m_top = '0; m_btm = '0; start_cyc = cyc;
      end
    end else begin
      t++;
      rb = res_bit(t);
      if (rb >= 0) begin
        m_sar[rb] = cmp_out;
        if (cmp_out) m_btm[rb + 3] = 1'b1;
        else m_top[rb + 3] = 1'b1;
      end
      if (t == 24) t = -1;
    end
    #1;
    check_outputs();
    if (eoc === 1'b1) begin
      chk("eoc_latency", cyc - start_cyc, 23);
      if (b2b && last_eoc >= 0) chk("eoc_period", cyc - last_eoc, 25);
      last_eoc = cyc;
    end
  endtask

  task automatic run_single(input bit noise, input logic [9:0] pat);
    step(1'b1, 1'b1, noise, pat);
    for (int i = 0; i < 27; i++) step(1'b1, 1'b0, noise, pat);
  endtask

  initial begin
    rst = 1'b0; cnvst = 1'b0; cmp_out = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 10'h000);
    chk("rst_not_sca1_top", {19'd0, fine_sca1_top_not}, 32'h1FFF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 10'h000);

    run_single(1'b0, 10'h3FF);
    chk("all1_sar", {22'd0, sar}, 32'h3FF);
    chk("all1_sca1_btm", {19'd0, fine_sca1_btm}, 32'h1FF8);
    chk("all1_sca2_top", {19'd0, fine_sca2_top}, 32'h1FF8);
    chk("all1_sca1_top", {19'd0, fine_sca1_top}, 32'h0);

    run_single(1'b0, 10'h000);
    chk("all0_sar", {22'd0, sar}, 32'h000);
    chk("all0_sca1_top", {19'd0, fine_sca1_top}, 32'h1FF8);
    chk("all0_sca2_btm", {19'd0, fine_sca2_btm}, 32'h1FF8);
    chk("all0_sca1_btm", {19'd0, fine_sca1_btm}, 32'h0);

    run_single(1'b1, 10'h2AA);
    chk("alt_sar", {22'd0, sar}, 32'h2AA);
    chk("alt_sca1_btm", {19'd0, fine_sca1_btm}, 32'h1550);
    chk("alt_sca1_top", {19'd0, fine_sca1_top}, 32'h0AA8);

    // Reset in the middle of the coarse phase, then no restart without cnvst.
    step(1'b1, 1'b1, 1'b1, 10'h155);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 10'h155);
    step(1'b0, 1'b1, 1'b1, 10'h155);
    chk("midrst_sar", {22'd0, sar}, 32'h0);
    chk("midrst_not_sca2_btm", {19'd0, fine_sca2_btm_not}, 32'h1FFF);
    chk("midrst_eoc", {31'd0, eoc}, 32'd0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 10'h155);
    chk("midrst_no_eoc_seen", last_eoc < cyc - 30 ? 32'd1 : 32'd0, 32'd1);

    // cnvst held high: back-to-back conversions.
    b2b = 1'b1; last_eoc = -1;
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b1, 10'($urandom));
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 10'h000);
    b2b = 1'b0;

    // Fully random traffic including cnvst glitches mid-conversion and rare resets.
    for (int i = 0; i < 600; i++) begin
      logic [9:0] pat;
      pat = 10'($urandom);
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0), 1'b1, pat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
